// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg : state, opcode and ALUOp encodings for the multicycle control
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // True on the final cycle of a legal instruction, i.e. the edge that retires it.
  function automatic logic retires(state_t s, logic mem_ready);
    case (s)
      MEMWB, RWB, BRANCH, JUMP, ADDIWB: retires = 1'b1;
      MEMWR:                            retires = mem_ready;
      default:                          retires = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control : main sequencing FSM of the multicycle MIPS datapath
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic [1:0]  ALUOp,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          OP_ADDI:      next_state = ADDIEX;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  next_state = mem_ready ? MEMWB : MEMRD;
      MEMWR:  next_state = mem_ready ? FETCH : MEMWR;
      EXEC:   next_state = RWB;
      ADDIEX: next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    illegal_op  = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        illegal_op = !(opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI});
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase
    // State is already FETCH in reset, but mem_ready could still raise IRWrite/PCWrite.
    if (!reset_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      instr_count <= 32'd0;
    else if (retires(state, mem_ready)) instr_count <= instr_count + 32'd1;
  end

endmodule

`default_nettype wire
